// File: rtl/mem_bridge.sv
// Bridges SLC-3 control-unit memory strobes to a registered-output BRAM and a
// single memory-mapped I/O word (switches in, hex display out).
module mem_bridge #(
   parameter int unsigned ADDR_W     = 16,
   parameter logic [15:0] IO_ADDR    = 16'hFFFF,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_ena_i,
   input  logic              mem_wr_i,
   input  logic [15:0]       addr_i,
   input  logic [15:0]       wdata_i,
   output logic [15:0]       rdata_o,
   output logic              rdata_valid_o,
   output logic              busy_o,
   output logic              bram_en_o,
   output logic              bram_we_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic [15:0]       bram_din_o,
   input  logic [15:0]       bram_dout_i,
   input  logic [15:0]       sw_i,
   output logic [15:0]       hex_o
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StHold} state_e;

   localparam logic [2:0] RdLat = 3'(RD_LATENCY);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [15:0]       sw_meta_q, sw_sync_q;
   logic [ADDR_W-1:0] addr_q;
   logic              io_q;
   logic [15:0]       sw_cap_q;
   logic [15:0]       rdata_q;
   logic [15:0]       hex_q;

   logic              io_hit;
   logic              accept;
   logic              rd_valid;
   logic [15:0]       rd_data;
   logic              en_c, we_c;
   logic [ADDR_W-1:0] baddr_c;
   logic [15:0]       din_c;

   assign io_hit = (addr_i == IO_ADDR);
   assign accept = (state_q == StIdle) && mem_ena_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      en_c     = 1'b0;
      we_c     = 1'b0;
      baddr_c  = '0;
      din_c    = '0;
      rd_valid = 1'b0;
      rd_data  = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (mem_ena_i) begin
               baddr_c = addr_i[ADDR_W-1:0];
               din_c   = wdata_i;
               en_c    = !io_hit;
               if (mem_wr_i) begin
                  we_c    = !io_hit;
                  state_d = StWrite;
               end else begin
                  cnt_d   = 3'd1;
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            // Enable stays high so the BRAM output register keeps advancing.
            en_c    = !io_q;
            baddr_c = addr_q;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == RdLat) begin
               rd_valid = 1'b1;
               rd_data  = io_q ? sw_cap_q : bram_dout_i;
               cnt_d    = '0;
               state_d  = mem_ena_i ? StHold : StIdle;
            end
         end
         StWrite: begin
            state_d = mem_ena_i ? StHold : StIdle;
         end
         StHold: begin
            if (!mem_ena_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         addr_q    <= '0;
         io_q      <= 1'b0;
         sw_cap_q  <= '0;
         rdata_q   <= '0;
         hex_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sw_meta_q <= sw_i;
         sw_sync_q <= sw_meta_q;
         if (accept) begin
            addr_q   <= addr_i[ADDR_W-1:0];
            io_q     <= io_hit;
            // Snapshot switches now so I/O reads see the same latency as BRAM.
            sw_cap_q <= sw_sync_q;
            if (mem_wr_i && io_hit) begin
               hex_q <= wdata_i;
            end
         end
         if (rd_valid) begin
            rdata_q <= rd_data;
         end
      end
   end

   // Outputs are forced low while reset is held so an aborted access cannot strobe.
   always_comb begin
      rdata_o       = reset ? '0 : rd_data;
      rdata_valid_o = !reset && rd_valid;
      busy_o        = !reset && (state_q != StIdle);
      bram_en_o     = !reset && en_c;
      bram_we_o     = !reset && we_c;
      bram_addr_o   = reset ? '0 : baddr_c;
      bram_din_o    = reset ? '0 : din_c;
      hex_o         = hex_q;
   end

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: BRAM behavioural model, reference memory,
// expected-read queue checked by a separate monitor process.
module tb_mem_bridge;

   localparam int LAT = 2;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_ena_i, mem_wr_i;
   logic [15:0] addr_i, wdata_i, sw_i;
   logic [15:0] rdata_o, bram_addr_o, bram_din_o, hex_o;
   logic        rdata_valid_o, busy_o, bram_en_o, bram_we_o;
   logic [15:0] bram_dout;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q[$];
   logic [15:0] ref_mem [0:255];
   logic [15:0] ref_hex;
   logic [15:0] last_rd;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_bridge #(
      .ADDR_W    (16),
      .IO_ADDR   (16'hFFFF),
      .RD_LATENCY(LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_ena_i    (mem_ena_i),
      .mem_wr_i     (mem_wr_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .rdata_valid_o(rdata_valid_o),
      .busy_o       (busy_o),
      .bram_en_o    (bram_en_o),
      .bram_we_o    (bram_we_o),
      .bram_addr_o  (bram_addr_o),
      .bram_din_o   (bram_din_o),
      .bram_dout_i  (bram_dout),
      .sw_i         (sw_i),
      .hex_o        (hex_o)
   );

   function automatic logic [15:0] init_val(input logic [7:0] a);
      if (a == 8'h40) return 16'h1234;
      return {~a, a} ^ 16'h0F0F;
   endfunction

   // BRAM with one internal stage plus an output register (two-cycle read).
   logic [15:0]  bmem [0:255];
   logic [255:0] bwr;
   logic         mem_clr;
   logic [15:0]  st1;
   always @(posedge clk) begin
      if (mem_clr) begin
         bwr <= '0;
      end else if (bram_en_o) begin
         if (bram_we_o) begin
            bmem[bram_addr_o[7:0]] <= bram_din_o;
            bwr[bram_addr_o[7:0]]  <= 1'b1;
         end
         st1       <= bwr[bram_addr_o[7:0]] ? bmem[bram_addr_o[7:0]] : init_val(bram_addr_o[7:0]);
         bram_dout <= st1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rdata_valid_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got pulse rdata=%0h expected none (cycle %0d)",
                        rdata_o, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("rdata", rdata_o, e.data);
               chk("valid_cycle", cyc, e.cyc);
            end
         end
      end
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_rdata"}, rdata_o, 0);
      chk({nm, "_valid"}, rdata_valid_o, 0);
      chk({nm, "_busy"}, busy_o, 0);
      chk({nm, "_en"}, bram_en_o, 0);
      chk({nm, "_we"}, bram_we_o, 0);
      chk({nm, "_addr"}, bram_addr_o, 0);
      chk({nm, "_din"}, bram_din_o, 0);
      chk({nm, "_hex"}, hex_o, 0);
   endtask

   // Idle with new switch value; long enough for the synchronizer to settle.
   task automatic gap(input logic [15:0] sw);
      sw_i = sw;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One control-unit access: mem_ena_i held for 'hold' cycles. Called at posedge+1.
   task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         input int hold);
      logic        io;
      int          d, maxc;
      logic [15:0] hex_before;
      exp_t        e;
      io         = (a == 16'hFFFF);
      d          = wr ? 1 : LAT;
      maxc       = (hold > d) ? hold : d;
      hex_before = ref_hex;
      mem_ena_i  = 1'b1;
      mem_wr_i   = wr;
      addr_i     = a;
      wdata_i    = wd;
      if (wr) begin
         if (io) ref_hex = wd;
         else ref_mem[a[7:0]] = wd;
      end else begin
         e.data  = io ? sw_i : ref_mem[a[7:0]];
         e.cyc   = cyc + LAT;
         exp_q.push_back(e);
         last_rd = e.data;
      end
      for (int k = 0; k <= maxc + 1; k++) begin
         @(negedge clk);
         chk("bram_en", bram_en_o, !io && (wr ? (k == 0) : (k <= LAT)));
         chk("bram_we", bram_we_o, !io && wr && (k == 0));
         chk("busy", busy_o, (k >= 1) && (k <= maxc));
         chk("hex", hex_o, (k == 0) ? hex_before : ref_hex);
         if (!io && (k == 0 || (!wr && k <= LAT))) chk("bram_addr", bram_addr_o, a);
         if (!io && wr && k == 0) chk("bram_din", bram_din_o, wd);
         if (k == maxc + 1) chk("rdata_hold", rdata_o, last_rd);
         @(posedge clk);
         #1;
         mem_ena_i = (k + 1 < hold);
         if (k == 0) begin
            addr_i   = 16'($urandom);
            wdata_i  = 16'($urandom);
            mem_wr_i = 1'($urandom);
         end
      end
      chk("valid_pulses_pending", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int r;
      reset     = 1'b1;
      mem_clr   = 1'b1;
      mem_ena_i = 1'b0;
      mem_wr_i  = 1'b0;
      addr_i    = '0;
      wdata_i   = '0;
      sw_i      = '0;
      ref_hex   = '0;
      last_rd   = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      reset   = 1'b0;
      mem_clr = 1'b0;
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1;

      access(1'b0, 16'h0040, 16'h0000, 3);
      gap(16'h0000);
      access(1'b1, 16'h0041, 16'hBEEF, 3);
      gap(16'h0000);
      access(1'b0, 16'h0041, 16'h0000, 3);
      gap(16'h5A5A);
      access(1'b1, 16'hFFFF, 16'h00A5, 3);
      gap(16'h5A5A);
      access(1'b0, 16'hFFFF, 16'h0000, 3);
      gap(16'h5A5A);
      access(1'b0, 16'h0040, 16'h0000, 6);
      gap(16'h5A5A);
      access(1'b0, 16'h0040, 16'h0000, 1);
      gap(16'h5A5A);

      // Reset asserted in cycle 1 of a read.
      mem_ena_i = 1'b1;
      mem_wr_i  = 1'b0;
      addr_i    = 16'h0040;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      mem_ena_i = 1'b0;
      ref_hex   = '0;
      last_rd   = '0;
      @(negedge clk);
      check_zero("reset_mid_read");
      @(posedge clk);
      #1;
      gap(16'h3C3C);
      access(1'b0, 16'h0041, 16'h0000, 3);

      for (int n = 0; n < 40; n++) begin
         gap(16'($urandom));
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            access(1'b0, 16'hFFFF, 16'h0000, int'($urandom_range(1, 6)));
         end else if (r == 1) begin
            access(1'b1, 16'hFFFF, 16'($urandom), int'($urandom_range(1, 6)));
         end else begin
            access(1'($urandom_range(0, 1)), 16'h0040 + 16'($urandom_range(0, 63)),
                   16'($urandom), int'($urandom_range(1, 6)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
